// File: rtl/usb_ctrl_req_engine.sv
// USB EP0 standard-request engine: collects the 8-byte SETUP packet, handles
// SET_ADDRESS / SET_CONFIGURATION / endpoint-halt features, forwards the rest.
module usb_ctrl_req_engine #(
  parameter int         NUM_EP     = 4,
  parameter bit         ADDR_DEFER = 1'b1,
  parameter logic [7:0] MAX_CFG    = 8'd1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_reset,
  input  logic              setup_tok,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  input  logic              rx_crc_err,
  input  logic              status_in_ack,
  output logic [6:0]        dev_addr,
  output logic [7:0]        cfg_value,
  output logic              configured,
  output logic [NUM_EP-1:0] ep_halt,
  output logic              ep0_stall,
  output logic              status_req,
  output logic              req_valid,
  output logic [7:0]        req_type,
  output logic [7:0]        req_code,
  output logic [15:0]       req_wvalue,
  output logic [15:0]       req_windex,
  output logic [15:0]       req_wlength
);

  typedef enum logic [1:0] {IDLE, COLLECT, DECODE, WAIT_STATUS} state_t;

  state_t      state_r, state_nxt;
  logic [2:0]  count_r;
  logic [7:0]  setup_buf_r [8];
  logic [6:0]  stage_addr_r, stage_addr_nxt;
  logic        stage_valid_r, stage_valid_nxt;

  logic [6:0]        dev_addr_nxt;
  logic [7:0]        cfg_nxt;
  logic [NUM_EP-1:0] halt_nxt;
  logic              stall_nxt, status_req_nxt, req_valid_nxt, load_fields;

  logic [7:0]  b_type, b_code;
  logic [15:0] w_value, w_index, w_length;
  logic [3:0]  feat_ep;
  logic        is_set_addr, is_set_cfg, is_feat, set_feat;
  logic        set_addr_ok, set_cfg_ok, feat_ok, dec_forward, dec_stall;

  assign b_type   = setup_buf_r[0];
  assign b_code   = setup_buf_r[1];
  assign w_value  = {setup_buf_r[3], setup_buf_r[2]};
  assign w_index  = {setup_buf_r[5], setup_buf_r[4]};
  assign w_length = {setup_buf_r[7], setup_buf_r[6]};
  assign feat_ep  = w_index[3:0];

  assign is_set_addr = (b_type == 8'h00) && (b_code == 8'h05);
  assign is_set_cfg  = (b_type == 8'h00) && (b_code == 8'h09);
  assign set_feat    = (b_code == 8'h03);
  assign is_feat     = (b_type == 8'h02) && ((b_code == 8'h03) || (b_code == 8'h01));

  assign set_addr_ok = (w_value <= 16'd127) && (w_index == 16'd0) && (w_length == 16'd0);
  assign set_cfg_ok  = (dev_addr != 7'd0) && (w_value[7:0] <= MAX_CFG);
  // EP0 halt requests are acknowledged but have no effect
  assign feat_ok     = (w_value == 16'd0) &&
                       ((feat_ep == 4'd0) ||
                        (configured && ({1'b0, feat_ep} < 5'(NUM_EP))));

  assign dec_forward = !(is_set_addr || is_set_cfg || is_feat);
  assign dec_stall   = (is_set_addr && !set_addr_ok) || (is_set_cfg && !set_cfg_ok) ||
                       (is_feat && !feat_ok);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (bus_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:        state_nxt = IDLE;
      COLLECT: begin
        if (rx_crc_err) begin
          state_nxt = IDLE;
        end else if (rx_data_valid && (count_r == 3'd7)) begin
          state_nxt = DECODE;
        end else begin
          state_nxt = COLLECT;
        end
      end
      DECODE:      state_nxt = (dec_forward || dec_stall) ? IDLE : WAIT_STATUS;
      WAIT_STATUS: state_nxt = status_in_ack ? IDLE : WAIT_STATUS;
      default:     state_nxt = IDLE;
    endcase
    if (setup_tok) begin
      state_nxt = COLLECT;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // Output and control next values
  always_comb begin
    dev_addr_nxt    = dev_addr;
    cfg_nxt         = cfg_value;
    halt_nxt        = ep_halt;
    stall_nxt       = ep0_stall;
    stage_addr_nxt  = stage_addr_r;
    stage_valid_nxt = stage_valid_r;
    status_req_nxt  = 1'b0;
    req_valid_nxt   = 1'b0;
    load_fields     = 1'b0;
    if (setup_tok) begin
      stall_nxt       = 1'b0;
      stage_valid_nxt = 1'b0;
    end else begin
      case (state_r)
        DECODE: begin
          if (dec_forward) begin
            req_valid_nxt = 1'b1;
            load_fields   = 1'b1;
          end else if (dec_stall) begin
            stall_nxt = 1'b1;
          end else begin
            status_req_nxt = 1'b1;
            if (is_set_addr) begin
              if (ADDR_DEFER) begin
                stage_addr_nxt  = w_value[6:0];
                stage_valid_nxt = 1'b1;
              end else begin
                dev_addr_nxt = w_value[6:0];
              end
            end else if (is_set_cfg) begin
              cfg_nxt  = w_value[7:0];
              halt_nxt = '0;
            end else begin
              for (int i = 1; i < NUM_EP; i++) begin
                if (feat_ep == 4'(i)) halt_nxt[i] = set_feat;
              end
            end
          end
        end
        WAIT_STATUS: begin
          if (status_in_ack && stage_valid_r) begin
            dev_addr_nxt    = stage_addr_r;
            stage_valid_nxt = 1'b0;
          end else begin
            stage_valid_nxt = stage_valid_r;
          end
        end
        default: stall_nxt = ep0_stall;
      endcase
    end
    halt_nxt[0] = 1'b0;
  end

  // Registered outputs and staged address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_addr <= 7'd0; cfg_value <= 8'd0; configured <= 1'b0; ep_halt <= '0;
      ep0_stall <= 1'b0; status_req <= 1'b0; req_valid <= 1'b0;
      req_type <= 8'd0; req_code <= 8'd0;
      req_wvalue <= 16'd0; req_windex <= 16'd0; req_wlength <= 16'd0;
      stage_addr_r <= 7'd0; stage_valid_r <= 1'b0;
    end else if (bus_reset) begin
      dev_addr <= 7'd0; cfg_value <= 8'd0; configured <= 1'b0; ep_halt <= '0;
      ep0_stall <= 1'b0; status_req <= 1'b0; req_valid <= 1'b0;
      req_type <= 8'd0; req_code <= 8'd0;
      req_wvalue <= 16'd0; req_windex <= 16'd0; req_wlength <= 16'd0;
      stage_addr_r <= 7'd0; stage_valid_r <= 1'b0;
    end else begin
      dev_addr      <= dev_addr_nxt;
      cfg_value     <= cfg_nxt;
      configured    <= (cfg_nxt != 8'd0);
      ep_halt       <= halt_nxt;
      ep0_stall     <= stall_nxt;
      status_req    <= status_req_nxt;
      req_valid     <= req_valid_nxt;
      stage_addr_r  <= stage_addr_nxt;
      stage_valid_r <= stage_valid_nxt;
      if (load_fields) begin
        req_type    <= b_type;
        req_code    <= b_code;
        req_wvalue  <= w_value;
        req_windex  <= w_index;
        req_wlength <= w_length;
      end
    end
  end

  // SETUP byte capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 3'd0;
      for (int i = 0; i < 8; i++) setup_buf_r[i] <= 8'd0;
    end else if (bus_reset) begin
      count_r <= 3'd0;
      for (int i = 0; i < 8; i++) setup_buf_r[i] <= 8'd0;
    end else if (setup_tok) begin
      count_r <= 3'd0;
    end else if ((state_r == COLLECT) && rx_data_valid && !rx_crc_err) begin
      setup_buf_r[count_r] <= rx_data;
      count_r              <= count_r + 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_usb_ctrl_req_engine.sv
// Directed bench for usb_ctrl_req_engine with default parameters
// (NUM_EP=4, ADDR_DEFER=1, MAX_CFG=1).
module tb_usb_ctrl_req_engine;

  logic        clk = 1'b0;
  logic        rst_n, bus_reset, setup_tok, rx_data_valid, rx_crc_err, status_in_ack;
  logic [7:0]  rx_data;
  logic [6:0]  dev_addr;
  logic [7:0]  cfg_value, req_type, req_code;
  logic        configured, ep0_stall, status_req, req_valid;
  logic [3:0]  ep_halt;
  logic [15:0] req_wvalue, req_windex, req_wlength;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  usb_ctrl_req_engine dut (
    .clk(clk), .rst_n(rst_n), .bus_reset(bus_reset), .setup_tok(setup_tok),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_crc_err(rx_crc_err),
    .status_in_ack(status_in_ack), .dev_addr(dev_addr), .cfg_value(cfg_value),
    .configured(configured), .ep_halt(ep_halt), .ep0_stall(ep0_stall),
    .status_req(status_req), .req_valid(req_valid), .req_type(req_type),
    .req_code(req_code), .req_wvalue(req_wvalue), .req_windex(req_windex),
    .req_wlength(req_wlength)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pkt holds byte 0 in the top byte; crc_at < 8 aborts with a CRC error at that byte
  task automatic send_setup(input logic [63:0] pkt, input int crc_at);
    setup_tok = 1'b1;
    tick();
    setup_tok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == crc_at) begin
        rx_crc_err = 1'b1;
        tick();
        rx_crc_err = 1'b0;
        break;
      end
      rx_data       = pkt[63-8*i -: 8];
      rx_data_valid = 1'b1;
      tick();
    end
    rx_data_valid = 1'b0;
  endtask

  task automatic ack();
    status_in_ack = 1'b1;
    tick();
    status_in_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus_reset = 1'b0; setup_tok = 1'b0; rx_data = 8'd0;
    rx_data_valid = 1'b0; rx_crc_err = 1'b0; status_in_ack = 1'b0;
    tick(); tick();
    check_val("rst_addr", 32'(dev_addr), 32'd0);
    check_val("rst_cfg", 32'(cfg_value), 32'd0);
    check_val("rst_configured", 32'(configured), 32'd0);
    check_val("rst_halt", 32'(ep_halt), 32'd0);
    check_val("rst_stall", 32'(ep0_stall), 32'd0);
    check_val("rst_status", 32'(status_req), 32'd0);
    check_val("rst_reqv", 32'(req_valid), 32'd0);
    check_val("rst_wvalue", 32'(req_wvalue), 32'd0);
    rst_n = 1'b1;
    tick();

    // SET_ADDRESS 5, deferred until status ACK
    send_setup(64'h00_05_05_00_00_00_00_00, 8);
    tick();
    check_val("sa_status", 32'(status_req), 32'd1);
    check_val("sa_addr_pre", 32'(dev_addr), 32'd0);
    tick();
    check_val("sa_status_pulse", 32'(status_req), 32'd0);
    check_val("sa_addr_wait", 32'(dev_addr), 32'd0);
    ack();
    check_val("sa_addr_post", 32'(dev_addr), 32'd5);

    // SET_CONFIGURATION 1 with address 5
    send_setup(64'h00_09_01_00_00_00_00_00, 8);
    tick();
    check_val("sc_status", 32'(status_req), 32'd1);
    check_val("sc_cfg", 32'(cfg_value), 32'd1);
    check_val("sc_configured", 32'(configured), 32'd1);
    ack();

    // Endpoint halt set / clear / out-of-range
    send_setup(64'h02_03_00_00_02_00_00_00, 8);
    tick();
    check_val("sf_halt", 32'(ep_halt), 32'h4);
    check_val("sf_status", 32'(status_req), 32'd1);
    ack();
    send_setup(64'h02_01_00_00_02_00_00_00, 8);
    tick();
    check_val("cf_halt", 32'(ep_halt), 32'h0);
    ack();
    send_setup(64'h02_03_00_00_05_00_00_00, 8);
    tick();
    check_val("sf5_stall", 32'(ep0_stall), 32'd1);
    check_val("sf5_status", 32'(status_req), 32'd0);
    check_val("sf5_halt", 32'(ep_halt), 32'h0);
    tick(); tick();
    check_val("stall_hold", 32'(ep0_stall), 32'd1);

    // GET_DESCRIPTOR is forwarded
    send_setup(64'h80_06_00_01_00_00_12_00, 8);
    tick();
    check_val("gd_reqv", 32'(req_valid), 32'd1);
    check_val("gd_type", 32'(req_type), 32'h80);
    check_val("gd_code", 32'(req_code), 32'h06);
    check_val("gd_wvalue", 32'(req_wvalue), 32'h0100);
    check_val("gd_wlength", 32'(req_wlength), 32'h0012);
    check_val("gd_status", 32'(status_req), 32'd0);
    check_val("gd_stall", 32'(ep0_stall), 32'd0);
    tick();
    check_val("gd_reqv_pulse", 32'(req_valid), 32'd0);
    check_val("gd_hold", 32'(req_wvalue), 32'h0100);

    // Bus reset, then SET_CONFIGURATION at address 0 stalls
    bus_reset = 1'b1;
    tick();
    bus_reset = 1'b0;
    check_val("br_addr", 32'(dev_addr), 32'd0);
    check_val("br_cfg", 32'(cfg_value), 32'd0);
    send_setup(64'h00_09_01_00_00_00_00_00, 8);
    tick();
    check_val("sc0_stall", 32'(ep0_stall), 32'd1);
    check_val("sc0_cfg", 32'(cfg_value), 32'd0);

    // CRC error mid-packet, stray bytes, then SET_ADDRESS 9
    send_setup(64'h00_05_07_00_00_00_00_00, 4);
    rx_data = 8'hAA; rx_data_valid = 1'b1;
    tick(); tick();
    rx_data_valid = 1'b0;
    check_val("crc_stall", 32'(ep0_stall), 32'd0);
    check_val("crc_status", 32'(status_req), 32'd0);
    send_setup(64'h00_05_09_00_00_00_00_00, 8);
    tick();
    check_val("sa9_status", 32'(status_req), 32'd1);
    ack();
    check_val("sa9_addr", 32'(dev_addr), 32'd9);
    check_val("sa9_stall", 32'(ep0_stall), 32'd0);

    // setup_tok in WAIT_STATUS discards the staged address
    send_setup(64'h00_05_07_00_00_00_00_00, 8);
    tick();
    send_setup(64'h80_06_00_01_00_00_12_00, 8);
    tick();
    ack();
    tick();
    check_val("discard_addr", 32'(dev_addr), 32'd9);

    // bus_reset beats status_in_ack in WAIT_STATUS
    send_setup(64'h00_09_01_00_00_00_00_00, 8);
    tick();
    ack();
    check_val("cfg_before_br", 32'(cfg_value), 32'd1);
    send_setup(64'h00_05_03_00_00_00_00_00, 8);
    tick();
    bus_reset = 1'b1; status_in_ack = 1'b1;
    tick();
    bus_reset = 1'b0; status_in_ack = 1'b0;
    check_val("brack_addr", 32'(dev_addr), 32'd0);
    check_val("brack_cfg", 32'(cfg_value), 32'd0);
    check_val("brack_configured", 32'(configured), 32'd0);
    ack();
    check_val("brack_idle_addr", 32'(dev_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_ctrl_req_engine.md
USB_CTRL_REQ_ENGINE -- requirements
Module: usb_ctrl_req_engine

Interface
REQ-001 Parameter NUM_EP, default 4, range 2..16: number of endpoints, EP0 included.
REQ-002 Parameter ADDR_DEFER, default 1: 1 = address applied after status-stage ACK; 0 = applied at decode.
REQ-003 Parameter MAX_CFG, default 1: highest accepted configuration value.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 bus_reset  in  1  synchronous USB bus-reset pulse.
REQ-008 setup_tok  in  1  1-cycle pulse: SETUP token for this device, EP0.
REQ-009 rx_data  in  8  setup data byte.
REQ-010 rx_data_valid  in  1  rx_data qualifier, one byte per cycle.
REQ-011 rx_crc_err  in  1  pulse: current data packet corrupt.
REQ-012 status_in_ack  in  1  pulse: host ACKed zero-length IN status stage.
REQ-013 dev_addr  out  7  active device address.
REQ-014 cfg_value  out  8  current configuration.
REQ-015 configured  out  1  cfg_value != 0.
REQ-016 ep_halt  out  NUM_EP  per-endpoint halt; bit 0 constant 0.
REQ-017 ep0_stall  out  1  EP0 protocol stall.
REQ-018 status_req  out  1  1-cycle pulse: request handled, send zero-length status.
REQ-019 req_valid  out  1  1-cycle pulse: request forwarded, not handled here.
REQ-020 req_type, req_code  out  8 each  bmRequestType, bRequest of forwarded request.
REQ-021 req_wvalue, req_windex, req_wlength  out  16 each  little-endian fields of forwarded request.

Function
REQ-022 FSM states: IDLE, COLLECT, DECODE, WAIT_STATUS.
REQ-023 setup_tok in any state -> COLLECT, byte count 0, ep0_stall cleared, staged address discarded.
REQ-024 COLLECT stores each valid byte at index count (3-bit), little-endian fields; after byte 7 -> DECODE next cycle.
REQ-025 rx_data_valid outside COLLECT ignored; bytes beyond 8 ignored.
REQ-026 rx_crc_err in COLLECT -> IDLE, no outputs change.
REQ-027 DECODE lasts one cycle; status_req, req_valid, ep0_stall, cfg_value and ep_halt updates are visible 2 cycles after the byte-7 cycle.
REQ-028 SET_ADDRESS (type 0x00, code 0x05): wValue<=127, wIndex=0, wLength=0 -> stage wValue[6:0], pulse status_req, go to WAIT_STATUS; otherwise stall.
REQ-029 ADDR_DEFER=1: dev_addr loads staged value the cycle after status_in_ack in WAIT_STATUS, then IDLE; ADDR_DEFER=0: dev_addr loads in DECODE, then WAIT_STATUS.
REQ-030 SET_CONFIGURATION (0x00, 0x09): requires dev_addr!=0 and wValue[7:0]<=MAX_CFG, else stall; on accept load cfg_value, clear all ep_halt, pulse status_req.
REQ-031 SET_FEATURE (0x02, 0x03) / CLEAR_FEATURE (0x02, 0x01) with wValue=0: ep=wIndex[3:0]; ep=0 accepted, no effect; 0<ep<NUM_EP and configured -> set/clear ep_halt[ep], pulse status_req; otherwise stall.
REQ-032 All other requests (any type/code) -> req_valid pulse with all five fields held until next DECODE.
REQ-033 Stall: ep0_stall=1 from DECODE+1 until next setup_tok or bus_reset; FSM -> IDLE.
REQ-034 Non-deferred accepted requests -> WAIT_STATUS; status_in_ack -> IDLE; status_in_ack outside WAIT_STATUS ignored.
REQ-035 bus_reset: same effect as rst_n, one cycle later; bus_reset wins over simultaneous setup_tok or status_in_ack.

Reset
REQ-036 rst_n low: FSM IDLE, count 0, dev_addr 0, cfg_value 0, configured 0, ep_halt 0, ep0_stall 0, status_req 0, req_valid 0, all req_* fields 0.

Verification
REQ-037 SETUP + 00 05 05 00 00 00 00 00, ADDR_DEFER=1 -> status_req pulse, dev_addr 0 until status_in_ack, then 5.
REQ-038 Address 5, then SETUP 00 09 01 00 00 00 00 00 -> cfg_value 1, configured 1; same with dev_addr 0 -> ep0_stall 1, cfg_value 0.
REQ-039 Configured, SET_FEATURE halt ep 2 -> ep_halt=4'b0100; CLEAR_FEATURE -> 0; ep 5 with NUM_EP=4 -> ep0_stall 1.
REQ-040 SETUP 80 06 00 01 00 00 12 00 -> req_valid pulse, req_wvalue 0x0100, req_wlength 0x0012, no status_req.
REQ-041 SETUP with CRC error after byte 3, then new SET_ADDRESS 9 -> dev_addr 9, no stall; setup_tok during WAIT_STATUS discards staged address.
REQ-042 bus_reset coinciding with status_in_ack in WAIT_STATUS -> dev_addr 0, cfg_value 0, FSM IDLE.
